// File: rtl/player_op_exec_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : player_op_exec_if
// Description : Collision-check handshake between the player-op executor
//               (master) and the board collision checker (slave).
//                 check_req   master->slave  one-cycle request pulse
//                 check_x     master->slave  candidate column (4 bits)
//                 check_y     master->slave  candidate row (5 bits)
//                 check_rot   master->slave  candidate rotation (2 bits)
//                 check_done  slave->master  one-cycle result-valid pulse
//                 check_ok    slave->master  candidate legal, qualified by done
// Revision    : 1.0  initial release
// ============================================================================
interface player_op_exec_if;
    logic       check_req;
    logic [3:0] check_x;
    logic [4:0] check_y;
    logic [1:0] check_rot;
    logic       check_done;
    logic       check_ok;

    modport master (
        output check_req,
        output check_x,
        output check_y,
        output check_rot,
        input  check_done,
        input  check_ok
    );

    modport slave (
        input  check_req,
        input  check_x,
        input  check_y,
        input  check_rot,
        output check_done,
        output check_ok
    );
endinterface
`default_nettype wire

// File: rtl/player_op_exec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : player_op_exec
// Description : Executes the pending player operation against the active
//               piece. Moves/spins are proposed to the collision checker and
//               written back when legal; DOWN is a hard drop that repeats
//               until the checker refuses (or BOARD_H steps), then requests a
//               lock. HOLD requests a swap once per piece. Every started op
//               ends with exactly one op_executed pulse.
// Ports       : clk, reset (sync, active-low)
//               op_type[2:0], op_enable          pending op from collector
//               cur_x[3:0], cur_y[4:0], cur_rot  active piece position
//               piece_locked                     re-arms hold permission
//               chk (master)                     collision-check handshake
//               pos_we, new_x/new_y/new_rot      accepted position write
//               lock_req, hold_req, op_executed  one-cycle pulses
//               hold_valid                       hold currently permitted
// Revision    : 1.0  initial release
// ============================================================================
module player_op_exec #(
    parameter int BOARD_H = 20
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic [2:0]      op_type,
    input  wire logic            op_enable,
    input  wire logic [3:0]      cur_x,
    input  wire logic [4:0]      cur_y,
    input  wire logic [1:0]      cur_rot,
    input  wire logic            piece_locked,
    player_op_exec_if.master     chk,
    output logic                 pos_we,
    output logic [3:0]           new_x,
    output logic [4:0]           new_y,
    output logic [1:0]           new_rot,
    output logic                 lock_req,
    output logic                 hold_req,
    output logic                 op_executed,
    output logic                 hold_valid
);

    // Op encodings shared with the input collector.
    localparam logic [2:0] c_NULL_OP       = 3'd0;
    localparam logic [2:0] c_LEFT_MOVE_OP  = 3'd1;
    localparam logic [2:0] c_RIGHT_MOVE_OP = 3'd2;
    localparam logic [2:0] c_SPIN_OP       = 3'd3;
    localparam logic [2:0] c_DOWN_MOVE_OP  = 3'd4;
    localparam logic [2:0] c_HOLD_OP       = 3'd5;

    localparam int                  c_ITER_W   = $clog2(BOARD_H + 1);
    localparam logic [c_ITER_W-1:0] c_ITER_CAP = c_ITER_W'(BOARD_H);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_COMMIT = 3'd3,
        S_ACK    = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [3:0]          r_cand_x;
    logic [4:0]          r_cand_y;
    logic [1:0]          r_cand_rot;
    logic [c_ITER_W-1:0] r_iter;
    logic                r_drop_more;   // hard drop accepted a step; probe one row lower
    logic                r_check_req;
    logic                r_pos_we;
    logic [3:0]          r_new_x;
    logic [4:0]          r_new_y;
    logic [1:0]          r_new_rot;
    logic                r_lock_req;
    logic                r_hold_req;
    logic                r_op_executed;
    logic                r_hold_valid;

    // Pulse outputs are set on the edge that enters the state in which they
    // are visible, so each is high for exactly the one cycle of that state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_op          <= c_NULL_OP;
            r_cand_x      <= 4'd0;
            r_cand_y      <= 5'd0;
            r_cand_rot    <= 2'd0;
            r_iter        <= '0;
            r_drop_more   <= 1'b0;
            r_check_req   <= 1'b0;
            r_pos_we      <= 1'b0;
            r_new_x       <= 4'd0;
            r_new_y       <= 5'd0;
            r_new_rot     <= 2'd0;
            r_lock_req    <= 1'b0;
            r_hold_req    <= 1'b0;
            r_op_executed <= 1'b0;
            r_hold_valid  <= 1'b1;
        end else begin
            r_check_req   <= 1'b0;
            r_pos_we      <= 1'b0;
            r_lock_req    <= 1'b0;
            r_hold_req    <= 1'b0;
            r_op_executed <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (op_enable && (op_type != c_NULL_OP)) begin
                        r_op        <= op_type;
                        r_cand_x    <= cur_x;
                        r_cand_y    <= cur_y;
                        r_cand_rot  <= cur_rot;
                        r_iter      <= '0;
                        r_drop_more <= 1'b0;
                        case (op_type)
                            c_LEFT_MOVE_OP: begin
                                // Column 0 cannot move left; no need to ask.
                                if (cur_x == 4'd0) begin
                                    r_state       <= S_ACK;
                                    r_op_executed <= 1'b1;
                                end else begin
                                    r_cand_x    <= cur_x - 4'd1;
                                    r_state     <= S_ISSUE;
                                    r_check_req <= 1'b1;
                                end
                            end
                            c_RIGHT_MOVE_OP: begin
                                r_cand_x    <= cur_x + 4'd1;
                                r_state     <= S_ISSUE;
                                r_check_req <= 1'b1;
                            end
                            c_SPIN_OP: begin
                                r_cand_rot  <= cur_rot + 2'd1;
                                r_state     <= S_ISSUE;
                                r_check_req <= 1'b1;
                            end
                            c_DOWN_MOVE_OP: begin
                                r_cand_y    <= cur_y + 5'd1;
                                r_state     <= S_ISSUE;
                                r_check_req <= 1'b1;
                            end
                            c_HOLD_OP: begin
                                r_state       <= S_ACK;
                                r_op_executed <= 1'b1;
                                if (r_hold_valid) begin
                                    r_hold_req   <= 1'b1;
                                    r_hold_valid <= 1'b0;
                                end
                            end
                            default: begin
                                // Unknown codes are retired so the collector never stalls.
                                r_state       <= S_ACK;
                                r_op_executed <= 1'b1;
                            end
                        endcase
                    end
                end

                S_ISSUE: begin
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (chk.check_done) begin
                        r_state <= S_COMMIT;
                        if (r_op == c_DOWN_MOVE_OP) begin
                            if (chk.check_ok && (r_iter < c_ITER_CAP)) begin
                                r_pos_we    <= 1'b1;
                                r_new_x     <= r_cand_x;
                                r_new_y     <= r_cand_y;
                                r_new_rot   <= r_cand_rot;
                                r_cand_y    <= r_cand_y + 5'd1;
                                r_iter      <= r_iter + c_ITER_W'(1);
                                r_drop_more <= 1'b1;
                            end else begin
                                r_lock_req  <= 1'b1;
                                r_drop_more <= 1'b0;
                            end
                        end else if (chk.check_ok) begin
                            r_pos_we  <= 1'b1;
                            r_new_x   <= r_cand_x;
                            r_new_y   <= r_cand_y;
                            r_new_rot <= r_cand_rot;
                        end
                    end
                end

                S_COMMIT: begin
                    if (r_drop_more) begin
                        r_drop_more <= 1'b0;
                        r_state     <= S_ISSUE;
                        r_check_req <= 1'b1;
                    end else begin
                        r_state       <= S_ACK;
                        r_op_executed <= 1'b1;
                    end
                end

                S_ACK: begin
                    r_state <= S_GAP;
                end

                S_GAP: begin
                    // Lets the collector retire the op before we sample op_type again.
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A new piece re-arms hold, even if a hold fires in the same cycle.
            if (piece_locked) begin
                r_hold_valid <= 1'b1;
            end
        end
    end

    assign chk.check_req = r_check_req;
    assign chk.check_x   = r_cand_x;
    assign chk.check_y   = r_cand_y;
    assign chk.check_rot = r_cand_rot;
    assign pos_we        = r_pos_we;
    assign new_x         = r_new_x;
    assign new_y         = r_new_y;
    assign new_rot       = r_new_rot;
    assign lock_req      = r_lock_req;
    assign hold_req      = r_hold_req;
    assign op_executed   = r_op_executed;
    assign hold_valid    = r_hold_valid;

endmodule
`default_nettype wire
